fft_bitrev_buffer: RTL

Parametrised ping-pong frame buffer feeding the FFT butterfly pipeline. Accepts an AXI-stream-style stream of complex samples, collects one frame of N = 2**LOG2N points per bank, and replays each completed frame in bit-reversed or natural order with per-sample index and frame framing. It sits between the sample source and the FFT core, replacing the fixed 8-point, 50-bit input handling with a configurable-size, double-buffered front end.

---
 rtl/fft_pkg.sv | 21 ++
 rtl/fft_pingpong_mem.sv | 26 ++
 rtl/fft_bitrev_buffer.sv | 137 +++++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// Shared types, limits and the index bit-reversal helper for the FFT input front end.
package fft_pkg;

    localparam int unsigned LOG2N_MAX  = 10;
    localparam int unsigned DATA_W_DEF = 50;
    localparam int unsigned IDX_W      = $clog2(LOG2N_MAX);

    typedef logic [DATA_W_DEF-1:0] sample_t;

    // Reverses the low 'width' bits of 'value'; bits at and above 'width' return as zero.
    function automatic logic [LOG2N_MAX-1:0] bitrev(input int unsigned width,
                                                    input logic [LOG2N_MAX-1:0] value);
        logic [LOG2N_MAX-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < LOG2N_MAX; i++) begin
            if (i < width) r[IDX_W'(i)] = value[IDX_W'(width - 1 - i)];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_pingpong_mem.sv
// Two-bank sample store: one write port, one asynchronous read port, bank chosen per port.
module fft_pingpong_mem #(
    parameter int unsigned LOG2N  = 3,
    parameter int unsigned DATA_W = 50
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic              wr_bank,
    input  logic [LOG2N-1:0]  wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_bank,
    input  logic [LOG2N-1:0]  rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam int unsigned N = 1 << LOG2N;

    logic [DATA_W-1:0] mem [2*N];

    always_ff @(posedge clk) begin
        if (wr_en) mem[{wr_bank, wr_addr}] <= wr_data;
    end

    assign rd_data = mem[{rd_bank, rd_addr}];

endmodule

// File: rtl/fft_bitrev_buffer.sv
// Ping-pong frame buffer: collects N-sample frames per bank and replays each
// completed frame in bit-reversed or natural order with index/last framing.
module fft_bitrev_buffer
    import fft_pkg::*;
#(
    parameter int unsigned LOG2N  = 3,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              bitrev_i,
    input  logic              s_tvalid,
    output logic              s_tready,
    input  logic [DATA_W-1:0] s_tdata,
    input  logic              s_tlast,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic [DATA_W-1:0] m_tdata,
    output logic [LOG2N-1:0]  m_tindex,
    output logic              m_tlast,
    output logic              frame_err_o
);

    typedef enum logic {W_IDLE, W_FILL}  wr_state_t;
    typedef enum logic {R_IDLE, R_DRAIN} rd_state_t;

    wr_state_t         wr_state_q, wr_state_d;
    rd_state_t         rd_state_q, rd_state_d;
    logic [1:0]        full_q;
    logic              wr_sel_q, rd_sel_q, mode_q, live_q;
    logic [LOG2N-1:0]  wr_cnt_q;
    logic [LOG2N:0]    rd_cnt_q;
    logic              wr_fire, wr_close, wr_early;
    logic              load_en, rd_done, rd_start, rd_step, rd_release;
    logic              rd_bank;
    logic [LOG2N-1:0]  rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic [1:0]        full_set, full_clr;

    assign s_tready = live_q && !full_q[wr_sel_q];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_state_q <= W_IDLE;
            rd_state_q <= R_IDLE;
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
        end
    end

    always_comb begin
        wr_state_d = wr_state_q;
        if (wr_fire) wr_state_d = (wr_close || wr_early) ? W_IDLE : W_FILL;
        rd_state_d = rd_state_q;
        if (rd_start)        rd_state_d = R_DRAIN;
        else if (rd_release) rd_state_d = R_IDLE;
    end

    // rd_cnt is the next slot to load; its top bit flags that slot N-1 is already in the output register.
    always_comb begin
        wr_fire    = s_tvalid && s_tready;
        wr_close   = wr_fire && (wr_cnt_q == '1);
        wr_early   = wr_fire && s_tlast && !wr_close;
        load_en    = !m_tvalid || m_tready;
        rd_done    = rd_cnt_q[LOG2N];
        rd_release = (rd_state_q == R_DRAIN) && rd_done && m_tready;
        rd_step    = (rd_state_q == R_DRAIN) && !rd_done && load_en;
        rd_start   = load_en && (((rd_state_q == R_IDLE) && full_q[rd_sel_q]) ||
                                 (rd_release && full_q[!rd_sel_q]));
        rd_bank    = rd_release ? !rd_sel_q : rd_sel_q;
        if (rd_start)    rd_addr = '0;
        else if (mode_q) rd_addr = LOG2N'(bitrev(LOG2N, LOG2N_MAX'(rd_cnt_q[LOG2N-1:0])));
        else             rd_addr = rd_cnt_q[LOG2N-1:0];
        full_set   = {wr_close && wr_sel_q, wr_close && !wr_sel_q};
        full_clr   = {rd_release && rd_sel_q, rd_release && !rd_sel_q};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            live_q      <= 1'b0;
            full_q      <= '0;
            wr_sel_q    <= 1'b0;
            rd_sel_q    <= 1'b0;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            mode_q      <= 1'b0;
            frame_err_o <= 1'b0;
        end else begin
            live_q      <= 1'b1;
            full_q      <= (full_q | full_set) & ~full_clr;
            frame_err_o <= (wr_close && !s_tlast) || wr_early;
            if (wr_close || wr_early) wr_cnt_q <= '0;
            else if (wr_fire)         wr_cnt_q <= wr_cnt_q + 1'b1;
            if (wr_close)   wr_sel_q <= !wr_sel_q;
            if (rd_release) rd_sel_q <= !rd_sel_q;
            if (rd_start) begin
                mode_q   <= bitrev_i;
                rd_cnt_q <= (LOG2N+1)'(1);
            end else if (rd_step) begin
                rd_cnt_q <= rd_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            m_tvalid <= 1'b0;
            m_tdata  <= '0;
            m_tindex <= '0;
            m_tlast  <= 1'b0;
        end else if (rd_start || rd_step) begin
            m_tvalid <= 1'b1;
            m_tdata  <= rd_data;
            m_tindex <= rd_start ? '0 : rd_cnt_q[LOG2N-1:0];
            m_tlast  <= !rd_start && (rd_cnt_q[LOG2N-1:0] == '1);
        end else if (rd_release) begin
            m_tvalid <= 1'b0;
            m_tlast  <= 1'b0;
        end
    end

    fft_pingpong_mem #(
        .LOG2N  (LOG2N),
        .DATA_W (DATA_W)
    ) u_mem (
        .clk     (clk_i),
        .wr_en   (wr_fire),
        .wr_bank (wr_sel_q),
        .wr_addr (wr_cnt_q),
        .wr_data (s_tdata),
        .rd_bank (rd_bank),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

endmodule
